// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: baud tick generation, input synchroniser, start/data/parity/stop deframing, valid/ready holding register.
// Optional parity checking (pen_i/eps_i/stick_i) is compiled in with `define UART_RX_PARITY_EN.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | line idle, waiting for a low sample
// START     | timing to start-bit midpoint, rejects glitches
// DATA      | sampling 5..8 data bits LSB first
// PARITY    | sampling the parity bit
// STOP      | sampling the first stop bit, completes the character
// WAIT_HIGH | stop bit was low, waiting for the line to return high
module uart_rx_deserializer #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  input  logic [15:0] divisor_i,
  input  logic [1:0]  wls_i,
`ifdef UART_RX_PARITY_EN
  input  logic        pen_i,
  input  logic        eps_i,
  input  logic        stick_i,
`endif
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        framing_err_o,
  output logic        parity_err_o,
  output logic        break_o,
  output logic        overrun_o,
  output logic        rx_busy_o
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID_TC  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_TC = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [15:0]            div_cnt_q;
  logic                   tick;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        zero_q, zero_d;
  logic        parity_en;
  logic        done;
  logic [2:0]  last_idx;
  logic        load;

  logic [7:0]  data_q;
  logic        valid_q;
  logic        fe_q;
  logic        brk_q;
  logic        ovr_q;

`ifdef UART_RX_PARITY_EN
  logic par_err_q, par_err_d;
  logic pe_hold_q;
  logic exp_par;

  assign parity_en = pen_i;
  assign exp_par   = stick_i ? ~eps_i : ((^shift_q) ^ ~eps_i);
`else
  assign parity_en = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Divisor 0 parks the counter at 0 with the tick suppressed.
  assign tick = (div_cnt_q == 16'd0) && (divisor_i != 16'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt_q <= 16'd0;
    end else if (div_cnt_q == 16'd0) begin
      div_cnt_q <= (divisor_i == 16'd0) ? 16'd0 : divisor_i - 16'd1;
    end else begin
      div_cnt_q <= div_cnt_q - 16'd1;
    end
  end

  assign last_idx = 3'd4 + {1'b0, wls_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      zero_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      zero_q    <= zero_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  // Bit timing uses a down-counter; each state acts when it reaches 0 on a tick.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    zero_d    = zero_q;
    done      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (tick && !rx_s) begin
          state_d   = START;
          cnt_d     = MID_TC;
          bit_idx_d = 3'd0;
          shift_d   = 8'd0;
          zero_d    = 1'b1;
`ifdef UART_RX_PARITY_EN
          par_err_d = 1'b0;
`endif
        end
      end
      START: begin
        if (tick) begin
          if (cnt_q == '0) begin
            cnt_d   = FULL_TC;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (cnt_q == '0) begin
            cnt_d            = FULL_TC;
            shift_d[bit_idx_q] = rx_s;
            zero_d           = zero_q & ~rx_s;
            if (bit_idx_q == last_idx) begin
              state_d = parity_en ? PARITY : STOP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      PARITY: begin
        if (tick) begin
          if (cnt_q == '0) begin
            cnt_d   = FULL_TC;
            zero_d  = zero_q & ~rx_s;
            state_d = STOP;
`ifdef UART_RX_PARITY_EN
            par_err_d = rx_s ^ exp_par;
`endif
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (cnt_q == '0) begin
            done    = 1'b1;
            state_d = rx_s ? IDLE : WAIT_HIGH;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      WAIT_HIGH: begin
        if (tick && rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A completing character may replace one that is being accepted in the same cycle.
  assign load = done && (!valid_q || rx_ready_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q    <= 8'd0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      brk_q     <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_hold_q <= 1'b0;
`endif
    end else begin
      ovr_q <= done && valid_q && !rx_ready_i;
      if (load) begin
        data_q    <= shift_q;
        valid_q   <= 1'b1;
        fe_q      <= ~rx_s;
        brk_q     <= zero_q & ~rx_s;
`ifdef UART_RX_PARITY_EN
        pe_hold_q <= par_err_q;
`endif
      end else if (valid_q && rx_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_data_o     = data_q;
  assign rx_valid_o    = valid_q;
  assign framing_err_o = fe_q;
  assign break_o       = brk_q;
  assign overrun_o     = ovr_q;
  assign rx_busy_o     = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err_o  = pe_hold_q;
`else
  assign parity_err_o  = 1'b0;
`endif

endmodule
